instrumented_adder_sequencer: RTL and testbench
===============================================

# instrumented_adder_sequencer

On-chip measurement sequencer that drives the instrumented adder from the stimulus side. It latches operands and a window length from the logic-analyser command bus, then runs one timed measurement: load operands, settle, enable the ring for exactly N clocks, capture the ring count and sum. It returns the results with a done flag, replacing manual LA bit-banging of the run/clear controls with a single start command.

## Interface
Parameters:
- `WIDTH`, 32, operand, sum and counter width
- `SETTLE_CYCLES`, 2, clocks between operand load and ring enable (≥1)

Ports:
- `wb_clk_i`  in  1  system clock
- `wb_rst_n`  in  1  asynchronous, active-low reset
- `cmd_start`  in  1  start request, sampled only in IDLE
- `cmd_abort`  in  1  return to IDLE from any state; overrides `cmd_start`
- `cmd_a`  in  WIDTH  operand A, latched at start
- `cmd_b`  in  WIDTH  operand B, latched at start
- `cmd_cycles`  in  WIDTH  measurement window N in clocks, latched at start
- `a_input`  out  WIDTH  operand A to adder
- `b_input`  out  WIDTH  operand B to adder
- `ring_en`  out  1  ring-oscillator enable to adder
- `count_clear`  out  1  synchronous clear of adder ring counter
- `ring_count`  in  WIDTH  ring counter value from adder
- `sum_in`  in  WIDTH  adder sum output
- `busy`  out  1  high in any state except IDLE and DONE
- `done`  out  1  high in DONE
- `result_count`  out  WIDTH  captured ring count
- `result_sum`  out  WIDTH  captured sum

## Operation
- States: IDLE, LOAD, SETTLE, RUN, CAPTURE, DONE.
- IDLE → LOAD on `cmd_start`=1. At the same edge, latch `cmd_a`, `cmd_b` and `cmd_cycles` into `a_input`, `b_input` and the window register N.
- LOAD (1 clk): `count_clear`=1. Then go to SETTLE.
- SETTLE: `SETTLE_CYCLES` clks; down-counter preset on entry. Then go to RUN, or straight to CAPTURE if N==0.
- RUN: `ring_en`=1 for exactly N clks. A WIDTH-bit down-counter is loaded with N−1 on entry. Exit to CAPTURE when it reaches 0. No wrap: N=2^WIDTH−1 is the maximum.
- CAPTURE (1 clk): `ring_en`=0. At the exit edge, register `ring_count`→`result_count` and `sum_in`→`result_sum`. Then go to DONE.
- DONE: `done`=1 and results held. `cmd_start`=1 re-latches operands and goes to LOAD (done drops). Otherwise stay.
- `cmd_abort`=1 in any state: next state is IDLE and `ring_en` drops at that edge. Result registers keep their previous values, `done`=0.
- `cmd_start` outside IDLE/DONE is ignored. Operand inputs are ignored except at the latching edge.
- Reset (async, any time, including mid-RUN): state=IDLE. All outputs are 0: `a_input`, `b_input`, `ring_en`, `count_clear`, `busy`, `done`, `result_count`, `result_sum`.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- Start sampled at edge 0 → LOAD in cycle 1. SETTLE is cycles 2..1+S. RUN is cycles 2+S..1+S+N. CAPTURE is cycle 2+S+N. `done` rises after edge 2+S+N.
- Defaults with N=10: `done` first visible after edge 14; `ring_en` high for exactly 10 sampled edges.
- N=0: `ring_en` never asserts and `done` rises after edge 2+S. `result_count` reflects the cleared counter.
- Abort and start sampled together in IDLE: abort wins, stay IDLE.

## Structure
- Package `instrumented_adder_pkg`: state enum (`SEQ_IDLE`..`SEQ_DONE`), default `WIDTH`, default `SETTLE_CYCLES`.
- One sub-module, `seq_down_counter`: WIDTH-bit loadable down-counter with `load`, `en` and `zero` outputs. It is shared by SETTLE and RUN; a single instance is reloaded on each entry.
- Top: FSM, operand/window latches and result registers.

## Test plan
- Reset mid-RUN (N=100, reset at cycle 20) → `ring_en`=0 immediately (async), all outputs 0, state IDLE after release.
- A=3, B=5, N=10, ring model increments when `ring_en`=1 → `ring_en` high exactly 10 cycles, `result_count`=10, `result_sum`=8, `done` after edge 14.
- N=0, A=0xFFFFFFFF, B=1 → no `ring_en` pulse, `result_sum`=0, `result_count`=0, `done` after edge 4.
- `cmd_abort` at cycle 6 of a run with N=50 → IDLE next edge, `done`=0, results keep prior values (from the previous test).
- Back-to-back: start again in DONE with A=7, B=9, N=4 → `count_clear` pulse, `result_sum`=16, `result_count`=4; `cmd_start` held during RUN is ignored.
- Start and abort asserted together in IDLE → stays IDLE, `busy`=0, operands not latched.

Source files
------------

// File: rtl/instrumented_adder_pkg.sv
// Shared types and defaults for the instrumented adder measurement sequencer.
package instrumented_adder_pkg;

    localparam int DEFAULT_WIDTH         = 32;
    localparam int DEFAULT_SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_SETTLE,
        SEQ_RUN,
        SEQ_CAPTURE,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter shared by the SETTLE and RUN phases; holds at zero.
module seq_down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/instrumented_adder_sequencer.sv
// Timed measurement sequencer: latch operands, clear ring counter, settle,
// enable the ring for exactly N clocks, then capture count and sum.
module instrumented_adder_sequencer
    import instrumented_adder_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] cmd_cycles,
    output logic [WIDTH-1:0] a_input,
    output logic [WIDTH-1:0] b_input,
    output logic             ring_en,
    output logic             count_clear,
    input  logic [WIDTH-1:0] ring_count,
    input  logic [WIDTH-1:0] sum_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_count,
    output logic [WIDTH-1:0] result_sum
);

    seq_state_t       r_state;
    logic [WIDTH-1:0] r_window;

    logic             w_zero;
    logic             w_cnt_load;
    logic             w_cnt_en;
    logic [WIDTH-1:0] w_cnt_val;
    logic             w_window_zero;

    assign w_window_zero = (r_window == '0);
    assign w_cnt_en      = (r_state == SEQ_SETTLE) || (r_state == SEQ_RUN);

    // The counter is preset on the edge that enters SETTLE and again on the
    // edge that enters RUN, so each phase sees its own fresh count.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        case (r_state)
            SEQ_LOAD: begin
                w_cnt_load = 1'b1;
                w_cnt_val  = WIDTH'(SETTLE_CYCLES - 1);
            end
            SEQ_SETTLE: begin
                if (w_zero) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = r_window - 1'b1;
                end
            end
            default: begin
                w_cnt_load = 1'b0;
            end
        endcase
    end

    seq_down_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .load     (w_cnt_load),
        .en       (w_cnt_en),
        .load_val (w_cnt_val),
        .zero     (w_zero)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state      <= SEQ_IDLE;
            r_window     <= '0;
            a_input      <= '0;
            b_input      <= '0;
            result_count <= '0;
            result_sum   <= '0;
        end else if (cmd_abort) begin
            r_state <= SEQ_IDLE;
        end else begin
            case (r_state)
                SEQ_IDLE, SEQ_DONE: begin
                    if (cmd_start) begin
                        a_input  <= cmd_a;
                        b_input  <= cmd_b;
                        r_window <= cmd_cycles;
                        r_state  <= SEQ_LOAD;
                    end
                end
                SEQ_LOAD: begin
                    r_state <= SEQ_SETTLE;
                end
                SEQ_SETTLE: begin
                    if (w_zero) begin
                        r_state <= w_window_zero ? SEQ_CAPTURE : SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    if (w_zero) begin
                        r_state <= SEQ_CAPTURE;
                    end
                end
                SEQ_CAPTURE: begin
                    result_count <= ring_count;
                    result_sum   <= sum_in;
                    r_state      <= SEQ_DONE;
                end
                default: begin
                    r_state <= SEQ_IDLE;
                end
            endcase
        end
    end

    // Control outputs decode straight from the state register, so reset and
    // abort drop them without an extra pipeline cycle.
    assign busy        = (r_state != SEQ_IDLE) && (r_state != SEQ_DONE);
    assign done        = (r_state == SEQ_DONE);
    assign ring_en     = (r_state == SEQ_RUN);
    assign count_clear = (r_state == SEQ_LOAD);

endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Directed bench for instrumented_adder_sequencer with a simple ring/adder model.
module tb_instrumented_adder_sequencer;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_abort = 1'b0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [31:0] cmd_cycles = '0;
    logic [31:0] a_input;
    logic [31:0] b_input;
    logic        ring_en;
    logic        count_clear;
    logic [31:0] ring_count = '0;
    logic [31:0] sum_in;
    logic        busy;
    logic        done;
    logic [31:0] result_count;
    logic [31:0] result_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instrumented_adder_sequencer dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .cmd_start    (cmd_start),
        .cmd_abort    (cmd_abort),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_cycles   (cmd_cycles),
        .a_input      (a_input),
        .b_input      (b_input),
        .ring_en      (ring_en),
        .count_clear  (count_clear),
        .ring_count   (ring_count),
        .sum_in       (sum_in),
        .busy         (busy),
        .done         (done),
        .result_count (result_count),
        .result_sum   (result_sum)
    );

    // Adder model: ring counter with synchronous clear, combinational sum.
    always @(posedge clk) begin
        if (count_clear)  ring_count <= '0;
        else if (ring_en) ring_count <= ring_count + 32'd1;
    end
    assign sum_in = a_input + b_input;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic measure(input logic [31:0] a, input logic [31:0] b, input int n,
                           input logic [31:0] exp_sum, input bit hold_start);
        int en_cnt;
        int last;
        cmd_a = a; cmd_b = b; cmd_cycles = n; cmd_start = 1'b1;
        tick();
        check("load_clear", {31'd0, count_clear}, 32'd1);
        check("load_busy",  {31'd0, busy},        32'd1);
        check("load_done",  {31'd0, done},        32'd0);
        check("load_a",     a_input,              a);
        check("load_b",     b_input,              b);
        if (!hold_start) cmd_start = 1'b0;
        cmd_a = 32'hDEAD_BEEF; cmd_b = 32'h1234_5678; cmd_cycles = 32'd7;
        en_cnt = 0;
        last = 2 + S + n;
        for (int k = 1; k <= last; k++) begin
            if (k == last) cmd_start = 1'b0;
            tick();
            if (ring_en) en_cnt++;
            if (k == 1) check("clear_pulse_end", {31'd0, count_clear}, 32'd0);
            if (k == last - 1) check("pre_done", {31'd0, done}, 32'd0);
        end
        check("done_high",    {31'd0, done},    32'd1);
        check("done_busy",    {31'd0, busy},    32'd0);
        check("done_ring_en", {31'd0, ring_en}, 32'd0);
        check("ring_en_cycles", en_cnt,         n);
        check("result_count", result_count,     n);
        check("result_sum",   result_sum,       exp_sum);
        check("a_held",       a_input,          a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_busy",  {31'd0, busy},    32'd0);
        check("rst_done",  {31'd0, done},    32'd0);
        check("rst_ring",  {31'd0, ring_en}, 32'd0);
        check("rst_a",     a_input,          32'd0);
        check("rst_rcnt",  result_count,     32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Main measurement: 3 + 5, N = 10
        measure(32'd3, 32'd5, 10, 32'd8, 1'b0);

        // Abort during RUN at cycle 6 of an N=50 run
        cmd_a = 32'h11; cmd_b = 32'h22; cmd_cycles = 32'd50; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        check("abort_pre_ring", {31'd0, ring_en}, 32'd1);
        cmd_abort = 1'b1;
        tick();
        check("abort_ring", {31'd0, ring_en}, 32'd0);
        check("abort_busy", {31'd0, busy},    32'd0);
        check("abort_done", {31'd0, done},    32'd0);
        check("abort_rcnt", result_count,     32'd10);
        check("abort_rsum", result_sum,       32'd8);
        cmd_abort = 1'b0;
        tick();
        check("abort_idle", {31'd0, busy}, 32'd0);

        // Start and abort together in IDLE: abort wins
        cmd_a = 32'h55; cmd_b = 32'h66; cmd_cycles = 32'd3;
        cmd_start = 1'b1; cmd_abort = 1'b1;
        tick();
        check("both_busy", {31'd0, busy}, 32'd0);
        check("both_a",    a_input,       32'h11);
        check("both_b",    b_input,       32'h22);
        cmd_start = 1'b0; cmd_abort = 1'b0;
        tick();
        check("both_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of an N=100 run
        cmd_a = 32'h21; cmd_b = 32'h12; cmd_cycles = 32'd100; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        for (int k = 1; k <= 19; k++) tick();
        check("mid_ring", {31'd0, ring_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ring",  {31'd0, ring_en},     32'd0);
        check("arst_busy",  {31'd0, busy},        32'd0);
        check("arst_clear", {31'd0, count_clear}, 32'd0);
        check("arst_a",     a_input,              32'd0);
        check("arst_b",     b_input,              32'd0);
        check("arst_rcnt",  result_count,         32'd0);
        check("arst_rsum",  result_sum,           32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_idle_busy", {31'd0, busy}, 32'd0);
        check("arst_idle_done", {31'd0, done}, 32'd0);

        // N = 0: no ring pulse, sum wraps to 0, counter cleared
        measure(32'hFFFF_FFFF, 32'd1, 0, 32'd0, 1'b0);

        // Short run to DONE, then back-to-back with start held through RUN
        measure(32'd1, 32'd2, 1, 32'd3, 1'b0);
        measure(32'd7, 32'd9, 4, 32'd16, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
